// File: rtl/gpio_lite_int_master7.sv
// Register-bus initiator for the GPIO lite subunit. Config requests become three writes; interrupts are read-cleared, then INPUT_VALUE is sampled.
// An irq seen in IDLE gives read7 one cycle later and evt_valid7 five cycles later. The event record holds while evt_ready7 is low.
module gpio_lite_int_master7 #(
  parameter logic [5:0]  ADDR_DIR  = 6'h04,
  parameter logic [5:0]  ADDR_OE   = 6'h08,
  parameter logic [5:0]  ADDR_OUT  = 6'h0C,
  parameter logic [5:0]  ADDR_IN   = 6'h10,
  parameter logic [5:0]  ADDR_STAT = 6'h20,
  parameter logic [15:0] IRQ_MASK  = 16'hFFFF
) (
  input  logic        pclk7,
  input  logic        reset7,
  input  logic        cfg_valid7,
  output logic        cfg_ready7,
  input  logic [15:0] cfg_dir7,
  input  logic [15:0] cfg_oe7,
  input  logic [15:0] cfg_out7,
  input  logic [15:0] irq7,
  output logic        read7,
  output logic        write7,
  output logic [5:0]  addr7,
  output logic [15:0] wdata7,
  input  logic [15:0] rdata7,
  output logic        evt_valid7,
  input  logic        evt_ready7,
  output logic [15:0] evt_status7,
  output logic [15:0] evt_value7,
  output logic [7:0]  evt_count7,
  output logic        busy7
);

  typedef enum logic [3:0] {
    IDLE, W_DIR, W_OE, W_OUT, R_STAT, C_STAT, R_VAL, C_VAL, PUSH
  } state_t;

  state_t      state;
  logic [15:0] dir_q, oe_q, out_q;
  logic [15:0] stat_q, val_q;
  logic [7:0]  count_q;

  assign evt_status7 = stat_q;
  assign evt_value7  = val_q;
  assign evt_count7  = count_q;

  // Bus strobes are registered alongside the state they belong to, so each
  // branch sets up the outputs of the state it is moving into.
  always_ff @(posedge pclk7) begin
    if (reset7) begin
      state      <= IDLE;
      dir_q      <= '0;
      oe_q       <= '0;
      out_q      <= '0;
      stat_q     <= '0;
      val_q      <= '0;
      count_q    <= '0;
      cfg_ready7 <= 1'b1;
      read7      <= 1'b0;
      write7     <= 1'b0;
      addr7      <= '0;
      wdata7     <= '0;
      evt_valid7 <= 1'b0;
      busy7      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_valid7) begin
            dir_q      <= cfg_dir7;
            oe_q       <= cfg_oe7;
            out_q      <= cfg_out7;
            state      <= W_DIR;
            write7     <= 1'b1;
            addr7      <= ADDR_DIR;
            wdata7     <= cfg_dir7;
            cfg_ready7 <= 1'b0;
            busy7      <= 1'b1;
          end else if ((irq7 & IRQ_MASK) != '0) begin
            state      <= R_STAT;
            read7      <= 1'b1;
            addr7      <= ADDR_STAT;
            cfg_ready7 <= 1'b0;
            busy7      <= 1'b1;
          end
        end
        W_DIR: begin
          state  <= W_OE;
          addr7  <= ADDR_OE;
          wdata7 <= oe_q;
        end
        W_OE: begin
          state  <= W_OUT;
          addr7  <= ADDR_OUT;
          wdata7 <= out_q;
        end
        W_OUT: begin
          state      <= IDLE;
          write7     <= 1'b0;
          addr7      <= '0;
          wdata7     <= '0;
          cfg_ready7 <= 1'b1;
          busy7      <= 1'b0;
        end
        R_STAT: begin
          state <= C_STAT;
          read7 <= 1'b0;
          addr7 <= '0;
        end
        C_STAT: begin
          stat_q <= rdata7;
          // A zero status means the interrupt was already cleared: no event.
          if (rdata7 == '0) begin
            state      <= IDLE;
            cfg_ready7 <= 1'b1;
            busy7      <= 1'b0;
          end else begin
            state <= R_VAL;
            read7 <= 1'b1;
            addr7 <= ADDR_IN;
          end
        end
        R_VAL: begin
          state <= C_VAL;
          read7 <= 1'b0;
          addr7 <= '0;
        end
        C_VAL: begin
          val_q      <= rdata7;
          state      <= PUSH;
          evt_valid7 <= 1'b1;
        end
        PUSH: begin
          if (evt_ready7) begin
            count_q    <= count_q + 8'd1;
            evt_valid7 <= 1'b0;
            state      <= IDLE;
            cfg_ready7 <= 1'b1;
            busy7      <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          read7      <= 1'b0;
          write7     <= 1'b0;
          addr7      <= '0;
          wdata7     <= '0;
          evt_valid7 <= 1'b0;
          cfg_ready7 <= 1'b1;
          busy7      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_lite_int_master7.sv
// Bench for gpio_lite_int_master7: GPIO subunit model, write/event scoreboards, directed and randomized traffic.
module tb_gpio_lite_int_master7;
  localparam logic [5:0] A_DIR = 6'h04, A_OE = 6'h08, A_OUT = 6'h0C, A_IN = 6'h10, A_STAT = 6'h20;

  logic pclk7 = 1'b0, reset7 = 1'b1;
  logic cfg_valid7 = 1'b0;
  logic [15:0] cfg_dir7 = '0, cfg_oe7 = '0, cfg_out7 = '0;
  logic [15:0] irq7, rdata7 = '0;
  logic evt_ready7 = 1'b0;
  logic cfg_ready7, read7, write7, evt_valid7, busy7;
  logic [5:0] addr7;
  logic [15:0] wdata7, evt_status7, evt_value7;
  logic [7:0] evt_count7;
  logic m_cfg_ready7, m_read7, m_write7, m_evt_valid7, m_busy7;
  logic [5:0] m_addr7;
  logic [15:0] m_wdata7, m_evt_status7, m_evt_value7;
  logic [7:0] m_evt_count7;

  int total = 0, bad = 0, pushed_events = 0, in_reads = 0;
  logic mon_en = 1'b0;
  logic [21:0] wq[$];
  logic [31:0] eq[$];
  logic [7:0] exp_cnt = '0;

  // subunit model state
  logic [15:0] stat = '0, set_req = '0, in_val = '0;
  logic spurious = 1'b0;
  logic rdy_rand = 1'b0, rdy_fixed = 1'b1;

  gpio_lite_int_master7 dut (
    .pclk7(pclk7), .reset7(reset7), .cfg_valid7(cfg_valid7), .cfg_ready7(cfg_ready7),
    .cfg_dir7(cfg_dir7), .cfg_oe7(cfg_oe7), .cfg_out7(cfg_out7), .irq7(irq7),
    .read7(read7), .write7(write7), .addr7(addr7), .wdata7(wdata7), .rdata7(rdata7),
    .evt_valid7(evt_valid7), .evt_ready7(evt_ready7), .evt_status7(evt_status7),
    .evt_value7(evt_value7), .evt_count7(evt_count7), .busy7(busy7));

  gpio_lite_int_master7 #(.IRQ_MASK(16'h00FF)) dut_m (
    .pclk7(pclk7), .reset7(reset7), .cfg_valid7(1'b0), .cfg_ready7(m_cfg_ready7),
    .cfg_dir7(16'h0), .cfg_oe7(16'h0), .cfg_out7(16'h0), .irq7(irq7),
    .read7(m_read7), .write7(m_write7), .addr7(m_addr7), .wdata7(m_wdata7), .rdata7(rdata7),
    .evt_valid7(m_evt_valid7), .evt_ready7(1'b1), .evt_status7(m_evt_status7),
    .evt_value7(m_evt_value7), .evt_count7(m_evt_count7), .busy7(m_busy7));

  always #5 pclk7 = ~pclk7;

  assign irq7 = stat;

  // GPIO subunit: registered rdata, INT_STATUS read-clears, newly set bits win.
  always @(posedge pclk7) begin
    if (read7 && addr7 == A_STAT) begin
      rdata7 <= spurious ? 16'h0 : stat;
      stat   <= set_req;
    end else begin
      stat   <= stat | set_req;
      rdata7 <= (read7 && addr7 == A_IN) ? in_val : 16'h0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  logic prev_vld = 1'b0, prev_acc = 1'b0;
  logic [15:0] prev_stat, prev_val;
  always @(negedge pclk7) begin
    if (mon_en) begin
      chk("strobe_excl", {31'b0, read7 & write7}, 32'd0);
      if (!read7 && !write7) chk("idle_addr", {26'b0, addr7}, 32'd0);
      if (read7 && addr7 == A_IN) in_reads++;
      if (write7) begin
        if (wq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write addr=%h data=%h", addr7, wdata7);
        end else begin
          logic [21:0] w;
          w = wq.pop_front();
          chk("wr_addr", {26'b0, addr7}, {26'b0, w[21:16]});
          chk("wr_data", {16'b0, wdata7}, {16'b0, w[15:0]});
        end
      end
      if (prev_vld && !prev_acc) begin
        chk("hold_valid", {31'b0, evt_valid7}, 32'd1);
        chk("hold_data", {evt_status7, evt_value7}, {prev_stat, prev_val});
      end
      if (evt_valid7 && evt_ready7) begin
        if (eq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_event status=%h value=%h", evt_status7, evt_value7);
        end else begin
          logic [31:0] e;
          e = eq.pop_front();
          chk("evt_record", {evt_status7, evt_value7}, e);
          chk("evt_count", {24'b0, evt_count7}, {24'b0, exp_cnt});
          exp_cnt <= exp_cnt + 8'd1;
        end
      end
      prev_vld  <= evt_valid7;
      prev_acc  <= evt_valid7 & evt_ready7;
      prev_stat <= evt_status7;
      prev_val  <= evt_value7;
    end
  end

  // Event sink ready: fixed or random, changed well clear of both clock edges.
  initial forever begin
    @(posedge pclk7); #2;
    evt_ready7 = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  task automatic tick();
    @(posedge pclk7); #1;
  endtask

  task automatic issue_cfg(input logic [15:0] d, input logic [15:0] o, input logic [15:0] u, input int n_exp);
    cfg_dir7 = d; cfg_oe7 = o; cfg_out7 = u; cfg_valid7 = 1'b1;
    if (n_exp > 0) wq.push_back({A_DIR, d});
    if (n_exp > 1) wq.push_back({A_OE, o});
    if (n_exp > 2) wq.push_back({A_OUT, u});
    tick();
    cfg_valid7 = 1'b0;
  endtask

  task automatic expect_evt(input logic [15:0] bits);
    eq.push_back({bits, in_val});
    pushed_events++;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((eq.size() != 0 || wq.size() != 0 || busy7 || set_req != 0) && n < budget) begin
      tick(); n++;
    end
    chk(name, {31'b0, n < budget}, 32'd1);
  endtask

  task automatic wait_stat_read(input string name);
    int n = 0;
    while (!(read7 && addr7 == A_STAT) && n < 50) begin tick(); n++; end
    chk(name, {31'b0, n < 50}, 32'd1);
  endtask

  initial begin
    int n;
    logic m_any;
    repeat (3) @(posedge pclk7);
    #1 reset7 = 1'b0;
    chk("rst_cfg_ready", {31'b0, cfg_ready7}, 32'd1);
    chk("rst_busy", {31'b0, busy7}, 32'd0);
    chk("rst_evt_valid", {31'b0, evt_valid7}, 32'd0);
    chk("rst_count", {24'b0, evt_count7}, 32'd0);
    chk("rst_addr", {26'b0, addr7}, 32'd0);
    chk("rst_strobes", {30'b0, read7, write7}, 32'd0);
    mon_en = 1'b1;

    // Reset during W_OE abandons the config sequence.
    issue_cfg(16'h1111, 16'h2222, 16'h3333, 2);
    tick();
    chk("mid_w_oe", {25'b0, write7, addr7}, {25'b0, 1'b1, A_OE});
    reset7 = 1'b1;
    tick();
    reset7 = 1'b0;
    chk("mid_rst_write", {31'b0, write7}, 32'd0);
    chk("mid_rst_idle", {30'b0, busy7, cfg_ready7}, 32'd1);
    tick();

    // Config: three back-to-back writes.
    chk("cfg_ready_idle", {31'b0, cfg_ready7}, 32'd1);
    issue_cfg(16'h00F0, 16'h0F0F, 16'hA5A5, 3);
    chk("cfg_w1", {24'b0, write7, cfg_ready7, addr7}, {24'b0, 1'b1, 1'b0, A_DIR});
    tick();
    chk("cfg_w2", {24'b0, write7, cfg_ready7, addr7}, {24'b0, 1'b1, 1'b0, A_OE});
    tick();
    chk("cfg_w3", {24'b0, write7, cfg_ready7, addr7}, {24'b0, 1'b1, 1'b0, A_OUT});
    tick();
    chk("cfg_done", {30'b0, write7, cfg_ready7}, 32'd1);

    // Interrupt latency.
    rdy_fixed = 1'b1;
    in_val = 16'h0013; set_req = 16'h0010; expect_evt(16'h0010);
    tick();
    set_req = '0;
    chk("lat_idle", {31'b0, busy7}, 32'd0);
    tick();
    chk("lat_read", {25'b0, read7, addr7}, {25'b0, 1'b1, A_STAT});
    n = 1;
    while (!evt_valid7 && n < 20) begin tick(); n++; end
    chk("lat_evt_cycle", n, 32'd5);
    chk("lat_evt_data", {evt_status7, evt_value7}, 32'h0010_0013);
    tick();
    chk("lat_count", {24'b0, evt_count7}, 32'd1);
    wait_drain("lat_drain", 50);

    // Mask: bit 8 is serviced by the default-mask unit only.
    in_val = 16'h0055; set_req = 16'h0100; expect_evt(16'h0100);
    tick();
    set_req = '0;
    m_any = 1'b0;
    repeat (10) begin tick(); m_any |= m_read7; end
    chk("mask_no_read", {31'b0, m_any}, 32'd0);
    wait_drain("mask_drain", 50);

    // Backpressure: four not-ready cycles in PUSH.
    rdy_fixed = 1'b0;
    tick();
    in_val = 16'h1234; set_req = 16'h8001; expect_evt(16'h8001);
    tick();
    set_req = '0;
    n = 0;
    while (!evt_valid7 && n < 20) begin tick(); n++; end
    repeat (4) begin
      chk("bp_hold", {evt_valid7, 7'b0, evt_count7, evt_status7}, {1'b1, 7'b0, 8'(pushed_events - 1), 16'h8001});
      tick();
    end
    rdy_fixed = 1'b1;
    tick();
    tick();
    chk("bp_accept", {23'b0, evt_valid7, evt_count7}, {23'b0, 1'b0, 8'(pushed_events)});
    wait_drain("bp_drain", 50);

    // Spurious: status reads back zero, so INPUT_VALUE is never read.
    n = in_reads;
    spurious = 1'b1; set_req = 16'h0004;
    tick();
    set_req = '0;
    wait_stat_read("spur_read");
    tick();
    tick();
    chk("spur_idle", {30'b0, busy7, read7}, 32'd0);
    chk("spur_no_in_read", in_reads, n);
    spurious = 1'b0;
    wait_drain("spur_drain", 50);

    // Bits set after the status read are picked up by a second service.
    in_val = 16'h0AAA; set_req = 16'h0003; expect_evt(16'h0003);
    tick();
    set_req = '0;
    wait_stat_read("late_read");
    tick();
    set_req = 16'h0C00; expect_evt(16'h0C00);
    tick();
    set_req = '0;
    wait_drain("late_drain", 80);

    // Priority: config and irq both seen in the same IDLE cycle.
    in_val = 16'h0077; set_req = 16'h0040; expect_evt(16'h0040);
    tick();
    set_req = '0;
    issue_cfg(16'hBEEF, 16'hCAFE, 16'h0102, 3);
    chk("prio_write_first", {24'b0, write7, read7, addr7}, {24'b0, 1'b1, 1'b0, A_DIR});
    repeat (4) tick();
    chk("prio_then_read", {24'b0, write7, read7, addr7}, {24'b0, 1'b0, 1'b1, A_STAT});
    wait_drain("prio_drain", 50);

    // Randomized traffic; enough events to wrap the 8-bit counter.
    rdy_rand = 1'b1;
    for (int i = 0; i < 262; i++) begin
      logic [15:0] bits;
      bits = 16'($urandom_range(1, 16'hFFFF));
      in_val = 16'($urandom);
      set_req = bits;
      expect_evt(bits);
      if ($urandom_range(0, 2) == 0)
        issue_cfg(16'($urandom), 16'($urandom), 16'($urandom), 3);
      else
        tick();
      set_req = '0;
      wait_drain("rand_drain", 300);
    end
    rdy_rand = 1'b0;
    repeat (3) tick();
    chk("final_wq_empty", wq.size(), 32'd0);
    chk("final_eq_empty", eq.size(), 32'd0);
    chk("final_count_wrap", {24'b0, evt_count7}, {24'b0, 8'(pushed_events % 256)});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    bad++;
    $display("FAIL watchdog_timeout time=%0t limit=600000", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
